// File: rtl/prio_code_display.sv
// Stability-filtered latch for the 8-to-3 priority encoder output, with an event counter and three seven-segment digits.
// Latency: a new input held steady commits STABLE_CYCLES edges after it is first registered. Segment outputs add no further delay.
// Backpressure: none. The block always accepts input, and bouncing input only restarts the settle timer.
//
// Ports:
//   clk, rst_n          : system clock; synchronous active-low reset
//   code[2:0], valid    : priority index and any-input-active flag from the encoder
//   code_q, valid_q     : last accepted index and its valid flag
//   evt_cnt[7:0]        : accepted-event counter, wraps from 255 to 0
//   evt_pulse           : one-cycle strobe on each counted event
//   seg_code            : active-low {dp,g,f,e,d,c,b,a}; hex of code_q, or a dash when not valid
//   seg_cnt_lo/hi       : active-low hex digits of evt_cnt[3:0] / evt_cnt[7:4]
module prio_code_display #(
    parameter int STABLE_CYCLES = 4     // minimum 2; the board build uses 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] code,
    input  logic       valid,
    output logic [2:0] code_q,
    output logic       valid_q,
    output logic [7:0] evt_cnt,
    output logic       evt_pulse,
    output logic [7:0] seg_code,
    output logic [7:0] seg_cnt_lo,
    output logic [7:0] seg_cnt_hi
);

    localparam int TIMER_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [7:0] SEG_DASH = 8'hBF;

    typedef enum logic {
        ST_STABLE,
        ST_SETTLE
    } state_t;

    state_t             r_state;
    logic [3:0]         r_in;
    logic [3:0]         r_cand;
    logic [TIMER_W-1:0] r_timer;
    logic [2:0]         r_code_q;
    logic               r_valid_q;
    logic [7:0]         r_evt_cnt;
    logic               r_evt_pulse;

    state_t             w_state_nxt;
    logic [3:0]         w_in_nxt;
    logic [3:0]         w_acc;
    logic [3:0]         w_cand_nxt;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic               w_commit;
    logic [2:0]         w_code_q_nxt;
    logic               w_valid_q_nxt;
    logic [7:0]         w_evt_cnt_nxt;
    logic               w_evt_pulse_nxt;

    // The code is zeroed while not valid, so a changing index behind
    // valid=0 never looks like new input.
    always_comb begin
        w_in_nxt = {valid, valid ? code : 3'b000};
        w_acc    = {r_valid_q, r_valid_q ? r_code_q : 3'b000};
    end

    // Next-state logic and commit decision.
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_timer_nxt = r_timer;
        w_commit    = 1'b0;

        unique case (r_state)
            ST_STABLE: begin
                if (r_in != w_acc) begin
                    w_state_nxt = ST_SETTLE;
                    w_cand_nxt  = r_in;
                    w_timer_nxt = TIMER_W'(1);
                end
            end
            ST_SETTLE: begin
                if (r_in == w_acc) begin
                    // Input went back to the accepted value, so it was a glitch.
                    w_state_nxt = ST_STABLE;
                end else if (r_in != r_cand) begin
                    w_cand_nxt  = r_in;
                    w_timer_nxt = TIMER_W'(1);
                end else if (r_timer == TIMER_LAST) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_STABLE;
                end else begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
            end
        endcase
    end

    // Commit effects. An invalid candidate clears valid_q but keeps the
    // last index, so a later reassertion of the same index counts again.
    always_comb begin
        w_code_q_nxt    = r_code_q;
        w_valid_q_nxt   = r_valid_q;
        w_evt_cnt_nxt   = r_evt_cnt;
        w_evt_pulse_nxt = 1'b0;
        if (w_commit) begin
            w_valid_q_nxt = r_cand[3];
            if (r_cand[3]) begin
                w_code_q_nxt    = r_cand[2:0];
                w_evt_cnt_nxt   = r_evt_cnt + 8'd1;
                w_evt_pulse_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_STABLE;
            r_in        <= 4'b0000;
            r_cand      <= 4'b0000;
            r_timer     <= '0;
            r_code_q    <= 3'b000;
            r_valid_q   <= 1'b0;
            r_evt_cnt   <= 8'd0;
            r_evt_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in        <= w_in_nxt;
            r_cand      <= w_cand_nxt;
            r_timer     <= w_timer_nxt;
            r_code_q    <= w_code_q_nxt;
            r_valid_q   <= w_valid_q_nxt;
            r_evt_cnt   <= w_evt_cnt_nxt;
            r_evt_pulse <= w_evt_pulse_nxt;
        end
    end

    // Active-low {dp,g,f,e,d,c,b,a}, with the decimal point off.
    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        logic [7:0] s;
        unique case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    always_comb begin
        code_q     = r_code_q;
        valid_q    = r_valid_q;
        evt_cnt    = r_evt_cnt;
        evt_pulse  = r_evt_pulse;
        seg_code   = r_valid_q ? hex_seg({1'b0, r_code_q}) : SEG_DASH;
        seg_cnt_lo = hex_seg(r_evt_cnt[3:0]);
        seg_cnt_hi = hex_seg(r_evt_cnt[7:4]);
    end

endmodule
